// File: rtl/ram_access_arbiter_pkg.sv
// Shared constants for the data RAM/IO path: exception codes, access widths
// and the arbiter state encoding.
package ram_access_arbiter_pkg;

  localparam int EXCEPTION_LEN = 4;

  localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK                = 4'd0;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ  = 4'd5;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_MISALIGNED_MEM    = 4'd6;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_WRITE = 4'd7;

  localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  // Code reported when the access unit never answers.
  function automatic logic [EXCEPTION_LEN-1:0] timeout_code(input logic is_read);
    return is_read ? EXCEP_INVALID_MEM_READ : EXCEP_INVALID_MEM_WRITE;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: with both requesting, the one not granted last
// time wins; otherwise the lone requester wins.
module rr_arbiter2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       any_o
);

  always_comb begin
    any_o = |req_i;
    if (&req_i) begin
      grant_o = ~last_grant_i;
    end else begin
      grant_o = req_i[1];
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Two-master arbiter in front of the data RAM/IO access unit: grants one
// request at a time, holds it stable into the unit, and acks the winner.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               mReq_In,
  input  logic [31:0]              m0Addr_In,
  input  logic [31:0]              m1Addr_In,
  input  logic [31:0]              m0Data_In,
  input  logic [31:0]              m1Data_In,
  input  logic [1:0]               m0Width_In,
  input  logic [1:0]               m1Width_In,
  input  logic                     m0IsRead_In,
  input  logic                     m1IsRead_In,
  output logic [1:0]               mAck_Out,
  output logic [31:0]              mData_Out,
  output logic [EXCEPTION_LEN-1:0] mException_Out,
  output logic [31:0]              ramAddr_Out,
  output logic [31:0]              ramData_Out,
  output logic [1:0]               ramWidth_Out,
  output logic                     ramIsRead_Out,
  output logic                     ramValid_Out,
  input  logic [EXCEPTION_LEN-1:0] ramException_In,
  input  logic [31:0]              ramData_In,
  input  logic                     ramOK_In
);

  arb_state_e state_q, state_d;

  logic                     owner_q, owner_d;
  logic                     last_grant_q, last_grant_d;
  logic [31:0]              addr_q, addr_d;
  logic [31:0]              wdata_q, wdata_d;
  logic [1:0]               width_q, width_d;
  logic                     is_read_q, is_read_d;
  logic [31:0]              rdata_q, rdata_d;
  logic [EXCEPTION_LEN-1:0] exc_q, exc_d;
  logic [TMO_W-1:0]         cnt_q, cnt_d;

  logic win;
  logic any_req;
  logic tmo_hit;
  logic ram_exc;

  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  req_width [2];
  logic        req_read  [2];

  always_comb begin
    req_addr[0]  = m0Addr_In;
    req_addr[1]  = m1Addr_In;
    req_wdata[0] = m0Data_In;
    req_wdata[1] = m1Data_In;
    req_width[0] = m0Width_In;
    req_width[1] = m1Width_In;
    req_read[0]  = m0IsRead_In;
    req_read[1]  = m1IsRead_In;
  end

  rr_arbiter2 u_rr (
    .req_i       (mReq_In),
    .last_grant_i(last_grant_q),
    .grant_o     (win),
    .any_o       (any_req)
  );

  assign tmo_hit = (cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign ram_exc = (ramException_In != EXCEP_OK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (any_req) state_d = ARB_ISSUE;
      ARB_ISSUE: if (ram_exc || ramOK_In || tmo_hit) state_d = ARB_RESP;
      ARB_RESP:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Request latch, completion capture and timeout counter.
  always_comb begin
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    width_d      = width_q;
    is_read_d    = is_read_q;
    rdata_d      = rdata_q;
    exc_d        = exc_q;
    cnt_d        = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          owner_d      = win;
          last_grant_d = win;
          addr_d       = req_addr[win];
          wdata_d      = req_wdata[win];
          width_d      = req_width[win];
          is_read_d    = req_read[win];
        end
      end
      ARB_ISSUE: begin
        cnt_d = cnt_q + TMO_W'(1);
        if (ram_exc) begin
          exc_d   = ramException_In;
          rdata_d = '0;
        end else if (ramOK_In) begin
          exc_d   = EXCEP_OK;
          rdata_d = is_read_q ? ramData_In : '0;
        end else if (tmo_hit) begin
          exc_d   = timeout_code(is_read_q);
          rdata_d = '0;
        end
      end
      ARB_RESP: cnt_d = '0;
      default:  cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      width_q      <= '0;
      is_read_q    <= 1'b0;
      rdata_q      <= '0;
      exc_q        <= EXCEP_OK;
      cnt_q        <= '0;
    end else begin
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      width_q      <= width_d;
      is_read_q    <= is_read_d;
      rdata_q      <= rdata_d;
      exc_q        <= exc_d;
      cnt_q        <= cnt_d;
    end
  end

  // Outputs decode from state so reset silences them without waiting for a clock.
  always_comb begin
    ramValid_Out   = (state_q == ARB_ISSUE);
    mAck_Out       = 2'b00;
    mData_Out      = '0;
    mException_Out = EXCEP_OK;
    if (state_q == ARB_RESP) begin
      mAck_Out[owner_q] = 1'b1;
      mData_Out         = rdata_q;
      mException_Out    = exc_q;
    end
    ramAddr_Out   = addr_q;
    ramData_Out   = wdata_q;
    ramWidth_Out  = width_q;
    ramIsRead_Out = is_read_q;
  end

endmodule
